// File: rtl/mel_filter_acc_if.sv
// mel_filter_acc_if
//   Bundles the three streams of the mel filter accumulator:
//     bin stream  : bin_data / bin_valid / bin_last  -> block, bin_ready  <- block
//     coeff ROM   : rom_addr <- block, rom_data -> block (one-cycle read latency)
//     mel stream  : mel_data / mel_valid / mel_last <- block, mel_ready -> block
//   slave  : the accumulator block itself
//   master : the environment (spectrum source, ROM, mel consumer)
interface mel_filter_acc_if #(
    parameter int P_W   = 32,
    parameter int ACC_W = 48
);
    logic [P_W-1:0]   bin_data;
    logic             bin_valid;
    logic             bin_last;
    logic             bin_ready;
    logic [8:0]       rom_addr;
    logic [7:0]       rom_data;
    logic [ACC_W-1:0] mel_data;
    logic             mel_valid;
    logic             mel_last;
    logic             mel_ready;

    modport slave (
        input  bin_data, bin_valid, bin_last, rom_data, mel_ready,
        output bin_ready, rom_addr, mel_data, mel_valid, mel_last
    );

    modport master (
        output bin_data, bin_valid, bin_last, rom_data, mel_ready,
        input  bin_ready, rom_addr, mel_data, mel_valid, mel_last
    );
endinterface

// File: rtl/mel_filter_acc.sv
// mel_filter_acc
//   Accumulates one frame of 256 power-spectrum bins into NUM_FILT triangular
//   mel filter energies, then streams the energies out.
//   Each bin looks up a weight w (Q0.8) and a filter index k from a 512x8 ROM:
//     acc[k]   += p * w        (rising edge of filter k, if k < NUM_FILT)
//     acc[k-1] += p * (256-w)  (falling edge of filter k-1, if k > 0)
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : mel_filter_acc_if.slave (bin in, ROM, mel out)
//   One bin every 4 cycles (IDLE, RD_W, RD_K, MAC); after a bin flagged
//   bin_last the block drains NUM_FILT words in OUT and clears its sums.
module mel_filter_acc #(
    parameter int NUM_FILT = 24,
    parameter int P_W      = 32,
    parameter int ACC_W    = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    mel_filter_acc_if.slave    bus
);
    localparam int PROD_W = P_W + 9;
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam int J_W    = $clog2(NUM_FILT);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [J_W-1:0]   J_LAST  = J_W'(NUM_FILT - 1);

    typedef enum logic [2:0] {IDLE, RD_W, RD_K, MAC, OUT} state_t;

    state_t                          state;
    logic [7:0]                      cnt;
    logic [P_W-1:0]                  p_r;
    logic                            last_r;
    logic [7:0]                      w_r;
    logic [7:0]                      k_r;
    logic [J_W-1:0]                  j;
    logic [NUM_FILT-1:0][ACC_W-1:0]  acc;
    logic [NUM_FILT-1:0][ACC_W-1:0]  acc_nxt;
    logic [PROD_W-1:0]               prod_w;
    logic [PROD_W-1:0]               prod_c;

    logic             ready_r;
    logic [8:0]       rom_addr_r;
    logic [ACC_W-1:0] mel_data_r;
    logic             mel_valid_r;
    logic             mel_last_r;

    logic bin_xfer;
    logic mel_xfer;

    assign bin_xfer = bus.bin_valid && ready_r;
    assign mel_xfer = mel_valid_r && bus.mel_ready;

    assign bus.bin_ready = ready_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.mel_data  = mel_data_r;
    assign bus.mel_valid = mel_valid_r;
    assign bus.mel_last  = mel_last_r;

    // Sum in a width that holds both operands plus carry, then clamp.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [PROD_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(ACC_MAX)) ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    // Full-width products; the complementary weight needs 9 bits (256 when w=0).
    always_comb begin
        prod_w = PROD_W'(p_r) * PROD_W'(w_r);
        prod_c = PROD_W'(p_r) * PROD_W'(9'd256 - {1'b0, w_r});
    end

    // Comparing k against i and i+1 per filter naturally drops k > NUM_FILT
    // and keeps k == NUM_FILT to the falling-edge term of the last filter.
    always_comb begin
        acc_nxt = acc;
        if (state == MAC) begin
            for (int i = 0; i < NUM_FILT; i++) begin
                if (k_r == 8'(i))
                    acc_nxt[i] = sat_add(acc[i], prod_w);
                if (k_r == 8'(i + 1))
                    acc_nxt[i] = sat_add(acc[i], prod_c);
            end
        end
    end

    // The ROM has one cycle of latency, so the address is always one state
    // ahead: {0,cnt} is presented in IDLE (w arrives in RD_W) and {1,cnt} is
    // loaded on the transfer edge (k arrives in RD_K).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p_r         <= '0;
            last_r      <= 1'b0;
            w_r         <= '0;
            k_r         <= '0;
            j           <= '0;
            acc         <= '0;
            ready_r     <= 1'b0;
            rom_addr_r  <= '0;
            mel_data_r  <= '0;
            mel_valid_r <= 1'b0;
            mel_last_r  <= 1'b0;
        end else begin
            acc <= acc_nxt;
            case (state)
                IDLE: begin
                    ready_r    <= 1'b1;
                    rom_addr_r <= {1'b0, cnt};
                    if (bin_xfer) begin
                        p_r        <= bus.bin_data;
                        last_r     <= bus.bin_last;
                        rom_addr_r <= {1'b1, cnt};
                        cnt        <= bus.bin_last ? 8'd0 : cnt + 8'd1;
                        ready_r    <= 1'b0;
                        state      <= RD_W;
                    end
                end
                RD_W: begin
                    w_r   <= bus.rom_data;
                    state <= RD_K;
                end
                RD_K: begin
                    k_r        <= bus.rom_data;
                    rom_addr_r <= {1'b0, cnt};
                    state      <= MAC;
                end
                MAC: begin
                    if (last_r) begin
                        // Word 0 must include this bin's contribution.
                        mel_data_r  <= acc_nxt[0];
                        mel_valid_r <= 1'b1;
                        mel_last_r  <= 1'b0;
                        j           <= '0;
                        state       <= OUT;
                    end else begin
                        ready_r <= 1'b1;
                        state   <= IDLE;
                    end
                end
                OUT: begin
                    if (mel_xfer) begin
                        if (j == J_LAST) begin
                            acc         <= '0;
                            j           <= '0;
                            mel_data_r  <= '0;
                            mel_valid_r <= 1'b0;
                            mel_last_r  <= 1'b0;
                            ready_r     <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            j          <= j + J_W'(1);
                            mel_data_r <= acc[j + J_W'(1)];
                            mel_last_r <= ((j + J_W'(1)) == J_LAST);
                        end
                    end
                end
                default: begin
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mel_filter_acc.sv
// tb_mel_filter_acc
//   Directed bench: main instance (NUM_FILT=24, P_W=32, ACC_W=48) plus a
//   16-bit accumulator instance for saturation. Both share one ROM image.
module tb_mel_filter_acc;
    localparam int NF = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mel_filter_acc_if #(.P_W(32), .ACC_W(48)) bif ();
    mel_filter_acc_if #(.P_W(32), .ACC_W(16)) sif ();

    mel_filter_acc #(.NUM_FILT(NF), .P_W(32), .ACC_W(48)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );
    mel_filter_acc #(.NUM_FILT(NF), .P_W(32), .ACC_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(sif)
    );

    logic [7:0] rom [512];
    always @(posedge clk) begin
        bif.rom_data <= rom[bif.rom_addr];
        sif.rom_data <= rom[sif.rom_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [47:0] got  [NF];
    logic [47:0] expv [NF];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bin(input logic [31:0] p, input logic last);
        int n;
        @(negedge clk);
        bif.bin_data  = p;
        bif.bin_last  = last;
        bif.bin_valid = 1'b1;
        n = 0;
        while (!bif.bin_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bin_ready_timeout", bif.bin_ready, 1);
        @(negedge clk);
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
    endtask

    // mel_ready is set for the coming edge first, then a transfer is
    // recorded only when valid and ready are both high for that edge.
    task automatic collect(input bit toggle);
        int idx, n;
        bit stalled;
        logic [47:0] held;
        idx = 0; n = 0; stalled = 0; held = '0;
        bif.mel_ready = 1'b0;
        while (idx < NF && n < 500) begin
            @(negedge clk);
            n++;
            bif.mel_ready = toggle ? ~bif.mel_ready : 1'b1;
            if (bif.mel_valid) begin
                if (stalled) chk("hold_stable", bif.mel_data, held);
                if (bif.mel_ready) begin
                    got[idx] = bif.mel_data;
                    chk($sformatf("mel_last[%0d]", idx), bif.mel_last, (idx == NF-1));
                    idx++;
                    stalled = 0;
                end else begin
                    held = bif.mel_data;
                    stalled = 1;
                end
            end
        end
        chk("word_count", idx, NF);
        @(negedge clk);
        chk("valid_after_frame", bif.mel_valid, 0);
        bif.mel_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < NF; i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], expv[i]);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NF; i++) expv[i] = '0;
    endtask

    // Frame of 256 bins, p=1, w=0, k=b%NF+1: every bin adds 256 to filter b%NF.
    task automatic full_frame_rom_and_exp();
        clear_exp();
        for (int b = 0; b < 256; b++) begin
            rom[b]       = 8'd0;
            rom[256 + b] = 8'(b % NF + 1);
            expv[b % NF] = expv[b % NF] + 48'd256;
        end
    endtask

    task automatic run_frame(input bit toggle, input string tag);
        for (int b = 0; b < 256; b++) begin
            send_bin(32'd1, b == 255);
            if (b == 5) chk("rom_addr_rd_w", bif.rom_addr, 9'h105);
        end
        collect(toggle);
        check_frame(tag);
    endtask

    initial begin
        int n, idx;
        logic [15:0] sat_got [3];
        for (int a = 0; a < 512; a++) rom[a] = 8'd0;
        bif.bin_data = '0; bif.bin_valid = 0; bif.bin_last = 0; bif.mel_ready = 1;
        sif.bin_data = '0; sif.bin_valid = 0; sif.bin_last = 0; sif.mel_ready = 1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_bin_ready", bif.bin_ready, 0);
        chk("rst_mel_valid", bif.mel_valid, 0);
        chk("rst_mel_last", bif.mel_last, 0);
        chk("rst_mel_data", bif.mel_data, 0);
        chk("rst_rom_addr", bif.rom_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_bin_ready", bif.bin_ready, 1);

        // Single bin: p=100, w=128, k=1, then flush with a zero-power last bin
        rom[0] = 8'd128; rom[256] = 8'd1; rom[1] = 8'd0; rom[257] = 8'd0;
        send_bin(32'd100, 1'b0);
        chk("ready_low_rd_w", bif.bin_ready, 0);
        chk("rom_addr_k", bif.rom_addr, 9'h100);
        @(negedge clk);
        chk("ready_low_rd_k", bif.bin_ready, 0);
        @(negedge clk);
        chk("ready_low_mac", bif.bin_ready, 0);
        chk("rom_addr_mac", bif.rom_addr, 9'h001);
        @(negedge clk);
        chk("ready_back_idle", bif.bin_ready, 1);
        send_bin(32'd0, 1'b1);
        collect(1'b0);
        clear_exp(); expv[0] = 48'd12800; expv[1] = 48'd12800;
        check_frame("single");

        // Edge indices on bin 0
        rom[0] = 8'd64; rom[256] = 8'd0;
        send_bin(32'd10, 1'b1); collect(1'b0);
        clear_exp(); expv[0] = 48'd640;
        check_frame("k0");
        rom[256] = 8'd24;
        send_bin(32'd10, 1'b1); collect(1'b0);
        clear_exp(); expv[NF-1] = 48'd1920;
        check_frame("kN");
        rom[256] = 8'd30;
        send_bin(32'd10, 1'b1); collect(1'b0);
        clear_exp();
        check_frame("k30");

        // Full frame, then same frame under toggling backpressure
        full_frame_rom_and_exp();
        run_frame(1'b0, "full");
        run_frame(1'b1, "bp");

        // Reset while bin 100 is in MAC, then a clean frame
        for (int b = 0; b <= 100; b++) send_bin(32'd1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bin_ready", bif.bin_ready, 0);
        chk("mid_rst_mel_valid", bif.mel_valid, 0);
        chk("mid_rst_mel_data", bif.mel_data, 0);
        chk("mid_rst_rom_addr", bif.rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, "post_rst");

        // Saturation on the 16-bit instance: two bins p=2^32-1, w=255, k=1
        rom[0] = 8'd255; rom[256] = 8'd1; rom[1] = 8'd255; rom[257] = 8'd1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            sif.bin_data  = 32'hFFFF_FFFF;
            sif.bin_last  = (b == 1);
            sif.bin_valid = 1'b1;
            n = 0;
            while (!sif.bin_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("sat_ready_timeout", sif.bin_ready, 1);
            @(negedge clk);
            sif.bin_valid = 1'b0;
            sif.bin_last  = 1'b0;
        end
        idx = 0; n = 0;
        for (int i = 0; i < 3; i++) sat_got[i] = '0;
        while (idx < NF && n < 200) begin
            @(negedge clk);
            n++;
            if (sif.mel_valid) begin
                if (idx < 3) sat_got[idx] = sif.mel_data;
                idx++;
            end
        end
        chk("sat_word_count", idx, NF);
        chk("sat_w0", sat_got[0], 16'hFFFF);
        chk("sat_w1", sat_got[1], 16'hFFFF);
        chk("sat_w2", sat_got[2], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mel_filter_acc.md
MEL_FILTER_ACC -- requirements
Module: mel_filter_acc

Interface
REQ-001 Parameter NUM_FILT, default 24, number of mel filters (legal 2..32).
REQ-002 Parameter P_W, default 32, power-spectrum bin width, unsigned.
REQ-003 Parameter ACC_W, default 48, per-filter accumulator and output width, unsigned.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 bin_data  input  P_W  power value of current FFT bin.
REQ-007 bin_valid  input  1  bin_data valid.
REQ-008 bin_last  input  1  qualifies bin 255 of a frame.
REQ-009 bin_ready  output  1  block accepts a bin this cycle.
REQ-010 rom_addr  output  9  address to 512x8 coefficient ROM.
REQ-011 rom_data  input  8  ROM read data, valid the cycle after rom_addr is presented.
REQ-012 mel_data  output  ACC_W  filter energy result.
REQ-013 mel_valid  output  1  mel_data valid.
REQ-014 mel_last  output  1  marks filter NUM_FILT-1.
REQ-015 mel_ready  input  1  downstream accepts mel_data.

Function
REQ-016 ROM layout: addr {0,bin[7:0]} = weight w (Q0.8); addr {1,bin[7:0]} = filter index k (0..NUM_FILT).
REQ-017 Bin counter (8 bits) SHALL increment per accepted bin, wrap 255->0, and clear on bin_last acceptance.
REQ-018 Transfer occurs on bin_valid && bin_ready; bin_ready SHALL be 1 only in IDLE.
REQ-019 FSM states: IDLE, RD_W, RD_K, MAC, OUT.
REQ-020 IDLE -> RD_W on bin transfer; bin_data, bin_last and counter captured; rom_addr = {0,cnt}.
REQ-021 RD_W -> RD_K: rom_addr = {1,cnt}; rom_data captured as w.
REQ-022 RD_K -> MAC: rom_data captured as k.
REQ-023 MAC: acc[k] += p*w if k<NUM_FILT; acc[k-1] += p*(256-w) if k>0; both in the same cycle.
REQ-024 Products SHALL be computed at full width (P_W+9 bits); accumulation SHALL saturate at 2^ACC_W-1.
REQ-025 k>NUM_FILT SHALL be treated as no contribution (no accumulator written).
REQ-026 MAC -> OUT if captured bin_last, else -> IDLE; throughput 1 bin per 4 cycles.
REQ-027 OUT: mel_valid=1, mel_data=acc[j], j from 0; j advances on mel_valid && mel_ready.
REQ-028 mel_last=1 when j==NUM_FILT-1; on that transfer all acc cleared, j=0, -> IDLE.
REQ-029 mel_data/mel_valid SHALL hold stable while mel_ready=0.
REQ-030 bin_valid during RD_W/RD_K/MAC/OUT SHALL be stalled (bin_ready=0), never dropped.
REQ-031 rom_addr SHALL be {0,cnt} in IDLE, OUT and MAC (don't-care content, defined value).

Reset
REQ-032 On rst_n=0: state IDLE, counter 0, j 0, all acc 0, bin_ready 0 during reset then 1 in IDLE, mel_valid 0, mel_last 0, mel_data 0, rom_addr 0.
REQ-033 Reset mid-frame or mid-OUT SHALL discard partial sums; next frame starts at bin 0.

Verification
REQ-034 Single bin: bin 0 p=100, ROM w=128,k=1 -> acc[1]=12800, acc[0]=12800; bin_ready low 3 cycles after transfer.
REQ-035 Edge indices: k=0,w=64,p=10 -> acc[0]=640 only; k=NUM_FILT,w=64,p=10 -> acc[NUM_FILT-1]=1920 only; k=30 -> no change.
REQ-036 Full frame 256 bins p=1, w=0, k=bin%NUM_FILT+1 -> OUT emits NUM_FILT words matching golden model, mel_last on word 23 only, acc zero afterwards.
REQ-037 Backpressure: mel_ready toggles every cycle during OUT -> each word emitted once, data stable while stalled, 24 transfers.
REQ-038 Saturation: ACC_W=16 override, p=2^P_W-1, w=255 repeated -> mel_data=16'hFFFF, no wrap.
REQ-039 Reset asserted in MAC of bin 100 -> outputs at reset values; next frame result equals clean-run result.
